// File: rtl/apb_reg_bank.sv
// APB4 completer register bank: NUM_REGS byte-strobed 32-bit registers, RO entries
// mirror hw_status, configurable wait states, PSLVERR on illegal accesses.
module apb_reg_bank #(
    parameter int unsigned         NUM_REGS    = 8,
    parameter int unsigned         ADDR_W      = 8,
    parameter int unsigned         WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [ADDR_W-1:0]       PADDR,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [31:0]             PWDATA,
    input  logic [3:0]              PSTRB,
    output logic [31:0]             PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [NUM_REGS*32-1:0]  hw_status,
    output logic [NUM_REGS*32-1:0]  reg_q,
    output logic [NUM_REGS-1:0]     wr_pulse
);

    localparam int unsigned IDX_W    = ADDR_W - 2;
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;
    logic               access;
    logic               commit;
    logic [IDX_W-1:0]   idx;
    logic [NUM_REGS-1:0] sel;
    logic               in_range;
    logic               ro_hit;
    logic               illegal;
    logic               wr_commit;
    logic [31:0]        rd_val;
    logic [NUM_REGS*32-1:0] ro_bits;
    logic               unused_hw;

    assign access = PSEL & PENABLE;
    assign idx    = PADDR[ADDR_W-1:2];

    // One-hot decode doubles as the range check: no bit set means idx >= NUM_REGS.
    always_comb begin
        sel    = '0;
        ro_hit = 1'b0;
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i] = 1'b1;
                ro_hit = RO_MASK[i];
                rd_val = reg_q[32*i +: 32];
            end
        end
        in_range = |sel;
        illegal  = !in_range || (PADDR[1:0] != 2'b00) || (PWRITE && ro_hit);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (PENABLE) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign wr_commit = commit && PWRITE && !illegal;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= '0;
            wr_pulse <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            PREADY   <= commit;
            PSLVERR  <= commit && illegal;
            wr_pulse <= wr_commit ? sel : '0;
            if (commit && !PWRITE) begin
                PRDATA <= illegal ? '0 : rd_val;
            end
        end
    end

    // RO entries carry no storage; reads and reg_q take hw_status directly.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign reg_q[32*g +: 32]   = hw_status[32*g +: 32];
            assign ro_bits[32*g +: 32] = '1;
        end else begin : g_rw
            logic [31:0] q;
            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    q <= '0;
                end else if (wr_commit && sel[g]) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (PSTRB[b]) begin
                            q[8*b +: 8] <= PWDATA[8*b +: 8];
                        end
                    end
                end
            end
            assign reg_q[32*g +: 32]   = q;
            assign ro_bits[32*g +: 32] = '0;
        end
    end

    assign unused_hw = ^(hw_status & ~ro_bits);

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: two instances (no wait / 3 wait states) behind separate selects,
// a cycle-level reference model, a per-cycle compare process and directed literal checks.
module tb_apb_reg_bank;

    logic        pclk = 1'b0;
    logic        preset;
    logic [7:0]  paddr;
    logic        psel [2];
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prd  [2];
    logic        prdy [2];
    logic        perr [2];
    logic [255:0] hw  [2];
    logic [255:0] rq  [2];
    logic [7:0]  wrp  [2];

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int npr [2];
    int np1 = 0;

    logic [31:0] mreg    [2][8];
    logic        m_rdy   [2];
    logic        m_err   [2];
    logic [31:0] m_prd   [2];
    logic [7:0]  m_pulse [2];
    int          acc     [2];

    always #5 pclk = ~pclk;

    apb_reg_bank #(.NUM_REGS(8), .ADDR_W(8), .WAIT_CYCLES(0), .RO_MASK(8'h04)) dut0 (
        .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prd[0]), .PREADY(prdy[0]),
        .PSLVERR(perr[0]), .hw_status(hw[0]), .reg_q(rq[0]), .wr_pulse(wrp[0])
    );

    apb_reg_bank #(.NUM_REGS(8), .ADDR_W(8), .WAIT_CYCLES(3), .RO_MASK(8'h00)) dut1 (
        .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prd[1]), .PREADY(prdy[1]),
        .PSLVERR(perr[1]), .hw_status(hw[1]), .reg_q(rq[1]), .wr_pulse(wrp[1])
    );

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [7:0] ro_of(input int d);
        return (d == 0) ? 8'h04 : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transfer completes once PSEL&PENABLE has been sampled on
    // 1+WAIT consecutive edges; that edge commits and the next cycle shows PREADY.
    initial begin : model
        int idx;
        logic ill;
        logic busy;
        logic [7:0] rom;
        forever begin
            @(posedge pclk);
            for (int d = 0; d < 2; d++) begin
                rom = ro_of(d);
                if (preset) begin
                    for (int i = 0; i < 8; i++) mreg[d][i] = '0;
                    m_rdy[d] = 1'b0; m_err[d] = 1'b0; m_prd[d] = '0; m_pulse[d] = '0; acc[d] = 0;
                end else begin
                    busy = m_rdy[d];
                    m_rdy[d] = 1'b0; m_err[d] = 1'b0; m_pulse[d] = '0;
                    if (busy || !(psel[d] && penable)) begin
                        acc[d] = 0;
                    end else begin
                        acc[d]++;
                        if (acc[d] == wc(d) + 1) begin
                            acc[d]   = 0;
                            m_rdy[d] = 1'b1;
                            idx = int'(paddr[7:2]);
                            ill = (idx >= 8) || (paddr[1:0] != 2'b00);
                            if (!ill && pwrite && rom[idx]) ill = 1'b1;
                            if (ill) begin
                                m_err[d] = 1'b1;
                                if (!pwrite) m_prd[d] = '0;
                            end else if (pwrite) begin
                                for (int b = 0; b < 4; b++)
                                    if (pstrb[b]) mreg[d][idx][8*b +: 8] = pwdata[8*b +: 8];
                                m_pulse[d][idx] = 1'b1;
                            end else begin
                                m_prd[d] = rom[idx] ? hw[d][32*idx +: 32] : mreg[d][idx];
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : cmp
        logic [7:0]  rom;
        logic [31:0] ev;
        npr[0] = 0;
        npr[1] = 0;
        forever begin
            @(negedge pclk);
            if (chk_on) begin
                for (int d = 0; d < 2; d++) begin
                    rom = ro_of(d);
                    chk($sformatf("pready%0d", d),   32'(prdy[d]), 32'(m_rdy[d]));
                    chk($sformatf("pslverr%0d", d),  32'(perr[d]), 32'(m_err[d]));
                    chk($sformatf("prdata%0d", d),   prd[d], m_prd[d]);
                    chk($sformatf("wr_pulse%0d", d), 32'(wrp[d]), 32'(m_pulse[d]));
                    for (int i = 0; i < 8; i++) begin
                        ev = rom[i] ? hw[d][32*i +: 32] : mreg[d][i];
                        chk($sformatf("reg_q%0d[%0d]", d, i), rq[d][32*i +: 32], ev);
                    end
                    if (prdy[d]) npr[d]++;
                end
                if (wrp[0][1]) np1++;
            end
        end
    end

    task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er, output int lat);
        psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pstrb = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat = 0; rd = '0; er = 1'b0;
        do begin
            @(posedge pclk); #1;
            lat++;
        end while (!prdy[d] && lat < 40);
        chk("pready_seen", 32'(prdy[d]), 32'd1);
        rd = prd[d];
        er = perr[d];
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    task automatic start_partial(input int d, input logic [7:0] a, input logic [31:0] wd, input int n);
        psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b1; pwdata = wd; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: finished=0 required=1 at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          base;
        preset = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        psel[0] = 1'b0; psel[1] = 1'b0; hw[0] = '0; hw[1] = '0;
        @(posedge pclk); #1;
        chk_on = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        chk("rst_pready",  32'(prdy[0]), 32'd0);
        chk("rst_pslverr", 32'(perr[0]), 32'd0);
        chk("rst_prdata",  prd[0], 32'd0);
        chk("rst_wr_pulse", 32'(wrp[0]), 32'd0);
        chk("rst_reg_q",   32'(|rq[1]), 32'd0);

        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, 8'(4*i), '0, 4'hF, rd, er, lat);
            chk("rd_reset", rd, 32'd0);
            chk("rd_reset_err", 32'(er), 32'd0);
            chk("lat_w0", lat, 32'd1);
        end

        xfer(0, 1'b1, 8'h04, 32'h11223344, 4'hF, rd, er, lat);
        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'b0101, rd, er, lat);
        chk("strb_merge", rq[0][63:32], 32'h11AD33EF);
        xfer(0, 1'b0, 8'h04, '0, 4'hF, rd, er, lat);
        chk("strb_readback", rd, 32'h11AD33EF);
        xfer(0, 1'b1, 8'h04, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        chk("zero_strb_keep", rq[0][63:32], 32'h11AD33EF);
        chk("wr_pulse_count", np1, 32'd3);

        xfer(1, 1'b1, 8'h08, 32'hA5A50F0F, 4'hF, rd, er, lat);
        chk("lat_w3_wr", lat, 32'd4);
        xfer(1, 1'b0, 8'h08, '0, 4'hF, rd, er, lat);
        chk("lat_w3_rd", lat, 32'd4);
        chk("w3_readback", rd, 32'hA5A50F0F);
        base = npr[1];
        start_partial(1, 8'h08, 32'hFFFFFFFF, 2);
        psel[1] = 1'b0; penable = 1'b0;
        idle(6);
        chk("abort_no_ready", npr[1] - base, 32'd0);
        chk("abort_keep", rq[1][95:64], 32'hA5A50F0F);

        hw[0][95:64] = 32'hCAFE0001;
        xfer(0, 1'b1, 8'h08, 32'h12345678, 4'hF, rd, er, lat);
        chk("ro_wr_err", 32'(er), 32'd1);
        chk("ro_keep", rq[0][95:64], 32'hCAFE0001);
        xfer(0, 1'b0, 8'h08, '0, 4'hF, rd, er, lat);
        chk("ro_rd", rd, 32'hCAFE0001);
        chk("ro_rd_err", 32'(er), 32'd0);
        xfer(0, 1'b1, 8'h20, 32'h87654321, 4'hF, rd, er, lat);
        chk("oob_wr_err", 32'(er), 32'd1);
        xfer(0, 1'b0, 8'h20, '0, 4'hF, rd, er, lat);
        chk("oob_rd_err", 32'(er), 32'd1);
        chk("oob_rd_zero", rd, 32'd0);
        xfer(0, 1'b0, 8'h04, '0, 4'hF, rd, er, lat);
        xfer(0, 1'b0, 8'h05, '0, 4'hF, rd, er, lat);
        chk("mis_rd_err", 32'(er), 32'd1);
        chk("mis_rd_zero", rd, 32'd0);
        xfer(0, 1'b1, 8'h05, 32'h00000000, 4'hF, rd, er, lat);
        chk("mis_wr_err", 32'(er), 32'd1);
        chk("mis_keep", rq[0][63:32], 32'h11AD33EF);
        chk("wr_pulse_count_err", np1, 32'd3);

        base = npr[0];
        xfer(0, 1'b1, 8'h0C, 32'h01020304, 4'hF, rd, er, lat);
        xfer(0, 1'b0, 8'h0C, '0, 4'hF, rd, er, lat);
        chk("b2b_rd", rd, 32'h01020304);
        xfer(0, 1'b1, 8'h10, 32'h55AA55AA, 4'hF, rd, er, lat);
        chk("b2b_reg4", rq[0][159:128], 32'h55AA55AA);
        chk("b2b_ready_count", npr[0] - base, 32'd3);

        base = npr[1];
        start_partial(1, 8'h0C, 32'hBADC0DE5, 2);
        preset = 1'b1; psel[1] = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        idle(4);
        chk("rst_mid_keep", rq[1][127:96], 32'd0);
        chk("rst_mid_no_ready", npr[1] - base, 32'd0);
        xfer(1, 1'b1, 8'h0C, 32'h00000077, 4'hF, rd, er, lat);
        chk("post_rst_lat", lat, 32'd4);
        chk("post_rst_err", 32'(er), 32'd0);
        xfer(1, 1'b0, 8'h0C, '0, 4'hF, rd, er, lat);
        chk("post_rst_rd", rd, 32'h00000077);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
